// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch unit: issues one memory request at a time and queues {pc, inst}
// pairs for decode; a redirect flushes the queue and drops any response still in flight.
module ifu_fetch_queue #(
  parameter int unsigned     XLEN         = 64,
  parameter int unsigned     ILEN         = 32,
  parameter int unsigned     QDEPTH       = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst
);

  localparam int unsigned     PW         = $clog2(QDEPTH);
  localparam int unsigned     CW         = PW + 1;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(QDEPTH);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_pc_mem   [QDEPTH];
  logic [ILEN-1:0] r_inst_mem [QDEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic w_req_fire;
  logic w_push;
  logic w_pop;
  logic w_unused_pc_lsbs;

  // Fetch PCs are word aligned, so the low redirect bits carry no information.
  assign w_unused_pc_lsbs = &{1'b0, redirect_pc[1:0]};

  // A same-cycle redirect withdraws the request so the stale PC is never accepted.
  assign imem_req_valid = !rst && !redirect_valid && (r_state == S_REQ) && (r_count < FULL_COUNT);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_push         = !rst && !redirect_valid && (r_state == S_WAIT) && imem_resp_valid;

  assign out_valid = !rst && (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_pc    = r_pc_mem[r_rd_ptr];
  assign out_inst  = r_inst_mem[r_rd_ptr];

  // NOTE: the queue storage has no reset; r_count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_req_pc;
      r_inst_mem[r_wr_ptr] <= imem_resp_data;
    end
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_VECTOR;
      r_req_pc   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      // A response arriving with the redirect retires the outstanding request;
      // otherwise it is still owed and must be swallowed in DROP.
      if (r_state == S_REQ) r_state <= S_REQ;
      else                  r_state <= imem_resp_valid ? S_REQ : S_DROP;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      case (r_state)
        S_REQ: begin
          if (w_req_fire) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PC_STEP;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT:  if (imem_resp_valid) r_state <= S_REQ;
        S_DROP:  if (imem_resp_valid) r_state <= S_REQ;
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: the bench plays instruction memory and decode by hand,
// cycle by cycle, and compares outputs against hand-computed values.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

  int vectors = 0;
  int miscompares = 0;

  ifu_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    out_ready       = 1'b0;
    tick();
    tick();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);

    // Memory stalls: request held with a stable address.
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", imem_req_valid, 1);
      chk("stall_req_addr", imem_req_addr, 64'h8000_0000);
      tick();
    end

    // Streaming fetch with 1-cycle responses and decode always ready.
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stream_req_valid", imem_req_valid, 1);
      chk("stream_req_addr", imem_req_addr, 64'h8000_0000 + 64'(4 * i));
      tick();
      chk("stream_wait_no_req", imem_req_valid, 0);
      chk("stream_empty_in_wait", out_valid, 0);
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0010_0013 + 32'(i);
      tick();
      imem_resp_valid = 1'b0;
      #1;
      chk("stream_out_valid", out_valid, 1);
      chk("stream_out_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
      chk("stream_out_inst", out_inst, 64'(32'h0010_0013 + 32'(i)));
    end

    // Pop the last streamed entry while 0x8000_000C is accepted, then fill the queue.
    tick();
    out_ready = 1'b0;
    chk("fill_wait_empty", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        chk("fill_req_addr", imem_req_addr, 64'h8000_000C + 64'(4 * k));
        tick();
      end
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hABCD_0000 + 32'(k);
      tick();
      imem_resp_valid = 1'b0;
      #1;
    end
    chk("full_no_req", imem_req_valid, 0);
    chk("full_head_pc", out_pc, 64'h8000_000C);
    chk("full_head_inst", out_inst, 64'hABCD_0000);
    tick();
    tick();
    chk("full_still_no_req", imem_req_valid, 0);

    // One pop releases exactly one new request.
    out_ready = 1'b1;
    #1;
    chk("pop_out_valid", out_valid, 1);
    tick();
    out_ready = 1'b0;
    #1;
    chk("after_pop_req_valid", imem_req_valid, 1);
    chk("after_pop_req_addr", imem_req_addr, 64'h8000_001C);
    chk("after_pop_head_pc", out_pc, 64'h8000_0010);
    tick();
    chk("refill_wait_no_req", imem_req_valid, 0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hABCD_0004;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    chk("refull_no_req", imem_req_valid, 0);

    // Drop to 3 entries, then a one-cycle reset.
    out_ready = 1'b1;
    tick();
    out_ready      = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("three_entries_req", imem_req_valid, 1);
    chk("three_entries_head", out_pc, 64'h8000_0014);
    rst = 1'b1;
    #1;
    chk("in_rst_req_valid", imem_req_valid, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_req_valid", imem_req_valid, 1);
    chk("post_rst_req_addr", imem_req_addr, 64'h8000_0000);

    // Redirect while waiting; the late response must be discarded.
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1003;
    #1;
    chk("redir_wait_no_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("drop_no_req_1", imem_req_valid, 0);
    tick();
    chk("drop_no_req_2", imem_req_valid, 0);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    #1;
    chk("drop_no_req_3", imem_req_valid, 0);
    tick();
    imem_resp_valid = 1'b0;
    #1;
    chk("drop_fifo_empty", out_valid, 0);
    chk("drop_next_req_valid", imem_req_valid, 1);
    chk("drop_next_req_addr", imem_req_addr, 64'h8000_1000);

    // Redirect colliding with a response and a pop.
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1111_1111;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    chk("coll_head_pc", out_pc, 64'h8000_1000);
    chk("coll_head_inst", out_inst, 64'h1111_1111);
    tick();
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h8000_2000;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h2222_2222;
    out_ready       = 1'b1;
    tick();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    out_ready       = 1'b0;
    #1;
    chk("coll_out_valid", out_valid, 0);
    chk("coll_state_req", imem_req_valid, 1);
    chk("coll_req_addr", imem_req_addr, 64'h8000_2000);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h3333_3333;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    chk("coll_refetch_pc", out_pc, 64'h8000_2000);
    chk("coll_refetch_inst", out_inst, 64'h3333_3333);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
